multi_read_port_lutram: RTL
===========================

// Module: multi_read_port_lutram
// PURPOSE
//   Distributed-RAM storage: one byte-masked write port, NUM_READ_PORT independent registered read ports.
//   Per-set valid bits, with a sequenced flush that invalidates every set.
//   Used for tag/metadata arrays in caches and TLBs needing several lookups per cycle.
//   Write-first mode forwards merged bytes per port.
// PARAMETERS
//   SINGLE_ENTRY_WIDTH_IN_BITS  64               entry width; multiple of `BYTE_LEN_IN_BITS
//   NUM_SET                     64               entries; power of 2
//   SET_PTR_WIDTH_IN_BITS       $clog2(NUM_SET)  set address width
//   WRITE_MASK_LEN              WIDTH/`BYTE_LEN_IN_BITS  byte-enable count
//   NUM_READ_PORT               2                read ports; >= 1
//   CONFIG_MODE                 "ReadFirst"      "ReadFirst" | "WriteFirst"
//   WITH_VALID_REG_ARRAY        "Yes"            "Yes" | "No"
//   FLUSH_SETS_PER_CYCLE        8                sets cleared per sweep cycle; power of 2, divides NUM_SET
// PORTS
//   clk_in                          in   1                  clock, posedge
//   reset_in                        in   1                  asynchronous reset, active-high
//   write_port_access_en_in         in   1                  write request
//   write_port_write_en_in          in   WRITE_MASK_LEN     byte enables
//   write_port_access_set_addr_in   in   SET_PTR            write set
//   write_port_data_in              in   WIDTH              write data
//   write_port_ready_out            out  1                  write accepted this cycle (~flush_busy_out)
//   read_port_access_en_in          in   NUM_READ_PORT      per-port read request
//   read_port_access_set_addr_in    in   NUM_READ_PORT*SET_PTR   port p at [p*SET_PTR +: SET_PTR]
//   read_port_data_out              out  NUM_READ_PORT*WIDTH     port p at [p*WIDTH +: WIDTH]
//   read_port_valid_out             out  NUM_READ_PORT      per-port valid
//   flush_req_in                    in   1                  start invalidate-all
//   flush_busy_out                  out  1                  sweep in progress
//   flush_done_out                  out  1                  one-cycle pulse at flush completion
// BEHAVIOUR
//   Reset (async assert): read data 0, read valid 0, valid array 0, FSM IDLE, busy 0, done 0. RAM contents not reset.
//   Write: at posedge, if access_en & |write_en & ready, each enabled byte lane is written;
//     valid[addr] <= 1. access_en with write_en==0 is a no-op. During busy, writes are dropped.
//   Read, latency 1 per port, all ports independent:
//     en=0 -> data 0, valid 0.
//     ReadFirst -> data = mem[addr] before this edge's write; valid = valid[addr] before this edge.
//     WriteFirst, hit (accepted write to same addr) -> data byte b = write_en[b] ? wdata[b] : mem[addr][b];
//       valid 1. Hit applies to every port that matches.
//     Busy -> valid 0 on every port; data as above.
//   WITH_VALID_REG_ARRAY="No": valid_out = registered access_en; flush_req_in gives done pulse next cycle; busy stays 0.
//   Flush FSM (valid array present): IDLE -> SWEEP on flush_req_in; ptr=0.
//     SWEEP: clear valid[ptr +: FLUSH_SETS_PER_CYCLE]; ptr += FLUSH_SETS_PER_CYCLE.
//       Last group -> DONE. SWEEP lasts NUM_SET/FLUSH_SETS_PER_CYCLE cycles.
//     DONE: flush_done_out=1 for one cycle, busy 0, -> IDLE.
//   flush_busy_out = (state==SWEEP). flush_req_in in SWEEP/DONE ignored; not queued.
//   Write + flush_req in the same IDLE cycle: write is accepted, then cleared by the sweep.
//   Reset mid-sweep: FSM to IDLE; valid array to 0.
// STRUCTURE
//   Shared package/header: CONFIG_MODE and WITH_VALID string constants; flush FSM state encoding (IDLE/SWEEP/DONE).
//   `BYTE_LEN_IN_BITS comes from parameters.vh.
//   Sub-module lutram_read_port: one per port (generate loop).
//     Inputs: addr, en, RAM row, valid bit, write-hit info.
//     Does forward merge and output registers.
//   Top holds RAM array (ram_style "distributed"), valid array, flush FSM.
// TESTING
//   Write addr 5 data 0x1122334455667788 mask 0xFF; next cycle read p0=5, p1=5 -> both ports 0x1122334455667788, valid 1.
//   ReadFirst: mem[3]=0xAA..AA, write 0x55..55 mask 0x0F to 3, same cycle read 3 -> 0xAA..AA; following read -> 0xAAAAAAAA55555555.
//   WriteFirst same stimulus -> same-cycle read 0xAAAAAAAA55555555, valid 1, on every port addressing 3.
//   Fill all 64 sets, pulse flush_req (FLUSH_SETS_PER_CYCLE=8) -> busy for 8 cycles, done pulse 1 cycle;
//     writes during busy dropped (ready 0); afterwards all reads valid 0.
//   Read with en=0, and read of never-written addr 9 -> data 0/valid 0, and valid 0, respectively.
//   Assert reset_in asynchronously in the 3rd sweep cycle -> busy, done, all valids 0 immediately; no done pulse.

Source files
------------

// File: rtl/multi_read_port_lutram_pkg.sv
// Shared constants and flush FSM encoding for the multi-read-port LUTRAM.
package multi_read_port_lutram_pkg;

  localparam int unsigned BYTE_LEN_IN_BITS = 8;

  localparam string CONFIG_READ_FIRST  = "ReadFirst";
  localparam string CONFIG_WRITE_FIRST = "WriteFirst";

  localparam string VALID_ARRAY_YES = "Yes";
  localparam string VALID_ARRAY_NO  = "No";

  typedef enum logic [1:0] {
    FLUSH_IDLE  = 2'd0,
    FLUSH_SWEEP = 2'd1,
    FLUSH_DONE  = 2'd2
  } flush_state_e;

endpackage

// File: rtl/lutram_read_port.sv
// One registered read port: optional write-first byte merge, valid gating and output registers.
module lutram_read_port
  import multi_read_port_lutram_pkg::*;
#(
  parameter int unsigned WIDTH          = 64,
  parameter int unsigned MASK_LEN       = WIDTH / BYTE_LEN_IN_BITS,
  parameter bit          IS_WRITE_FIRST = 1'b0,
  parameter bit          HAS_VALID      = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic [WIDTH-1:0]    i_row,
  input  logic                i_valid_bit,
  input  logic                i_busy,
  input  logic                i_write_hit,
  input  logic [MASK_LEN-1:0] i_write_mask,
  input  logic [WIDTH-1:0]    i_write_data,
  output logic [WIDTH-1:0]    o_data,
  output logic                o_valid
);

  logic [WIDTH-1:0] w_merged;
  logic [WIDTH-1:0] w_data_next;
  logic             w_valid_next;
  logic             w_forward;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  always_comb begin
    w_merged = i_row;
    for (int unsigned b = 0; b < MASK_LEN; b++) begin
      if (i_write_mask[b]) begin
        w_merged[b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS] =
          i_write_data[b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS];
      end
    end
  end

  assign w_forward = IS_WRITE_FIRST && i_write_hit;

  always_comb begin
    w_data_next  = '0;
    w_valid_next = 1'b0;
    if (i_en) begin
      w_data_next = w_forward ? w_merged : i_row;
      // Without a valid array every enabled read reports valid.
      if (HAS_VALID) begin
        w_valid_next = !i_busy && (w_forward || i_valid_bit);
      end else begin
        w_valid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_data  <= w_data_next;
      r_valid <= w_valid_next;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/multi_read_port_lutram.sv
// Distributed-RAM array with one byte-masked write port, N registered read ports,
// per-set valid bits and a grouped flush sweep.
module multi_read_port_lutram
  import multi_read_port_lutram_pkg::*;
#(
  parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int unsigned NUM_SET                    = 64,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
  parameter int unsigned WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / BYTE_LEN_IN_BITS,
  parameter int unsigned NUM_READ_PORT              = 2,
  parameter string       CONFIG_MODE                = "ReadFirst",
  parameter string       WITH_VALID_REG_ARRAY       = "Yes",
  parameter int unsigned FLUSH_SETS_PER_CYCLE       = 8
) (
  input  logic                                                 clk_in,
  input  logic                                                 reset_in,
  input  logic                                                 write_port_access_en_in,
  input  logic [WRITE_MASK_LEN-1:0]                            write_port_write_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                     write_port_access_set_addr_in,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]                write_port_data_in,
  output logic                                                 write_port_ready_out,
  input  logic [NUM_READ_PORT-1:0]                             read_port_access_en_in,
  input  logic [NUM_READ_PORT*SET_PTR_WIDTH_IN_BITS-1:0]       read_port_access_set_addr_in,
  output logic [NUM_READ_PORT*SINGLE_ENTRY_WIDTH_IN_BITS-1:0]  read_port_data_out,
  output logic [NUM_READ_PORT-1:0]                             read_port_valid_out,
  input  logic                                                 flush_req_in,
  output logic                                                 flush_busy_out,
  output logic                                                 flush_done_out
);

  localparam int unsigned WIDTH          = SINGLE_ENTRY_WIDTH_IN_BITS;
  localparam int unsigned AW             = SET_PTR_WIDTH_IN_BITS;
  localparam bit          IS_WRITE_FIRST = (CONFIG_MODE == CONFIG_WRITE_FIRST);
  localparam bit          HAS_VALID      = (WITH_VALID_REG_ARRAY == VALID_ARRAY_YES);
  localparam int unsigned NUM_GROUPS     = NUM_SET / FLUSH_SETS_PER_CYCLE;
  localparam int unsigned GROUP_PTR_W    = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  logic               w_write_accept;
  logic               w_flush_busy;
  logic               w_flush_done;
  logic [NUM_SET-1:0] w_valid_array;

  (* ram_style = "distributed" *) logic [WIDTH-1:0] r_mem [NUM_SET];

  assign w_write_accept = write_port_access_en_in && (|write_port_write_en_in) && !w_flush_busy;

  // Storage is intentionally not reset; the valid bits carry entry state.
  always_ff @(posedge clk_in) begin
    if (w_write_accept) begin
      for (int unsigned b = 0; b < WRITE_MASK_LEN; b++) begin
        if (write_port_write_en_in[b]) begin
          r_mem[write_port_access_set_addr_in][b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS] <=
            write_port_data_in[b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS];
        end
      end
    end
  end

  if (HAS_VALID) begin : g_valid
    flush_state_e           r_state;
    flush_state_e           w_state_next;
    logic [GROUP_PTR_W-1:0] r_group;
    logic [GROUP_PTR_W-1:0] w_group_next;
    logic [NUM_SET-1:0]     r_valid;
    logic [NUM_SET-1:0]     w_valid_next;
    logic                   w_last_group;

    assign w_last_group = (r_group == GROUP_PTR_W'(NUM_GROUPS - 1));

    always_comb begin
      w_state_next = r_state;
      w_group_next = r_group;
      case (r_state)
        FLUSH_IDLE: begin
          if (flush_req_in) begin
            w_state_next = FLUSH_SWEEP;
            w_group_next = '0;
          end
        end
        FLUSH_SWEEP: begin
          w_group_next = r_group + 1'b1;
          if (w_last_group) begin
            w_state_next = FLUSH_DONE;
          end
        end
        FLUSH_DONE:  w_state_next = FLUSH_IDLE;
        default:     w_state_next = FLUSH_IDLE;
      endcase
    end

    // A write accepted alongside flush_req lands first; the sweep clears it later.
    always_comb begin
      w_valid_next = r_valid;
      if (r_state == FLUSH_SWEEP) begin
        w_valid_next[r_group * FLUSH_SETS_PER_CYCLE +: FLUSH_SETS_PER_CYCLE] = '0;
      end else if (w_write_accept) begin
        w_valid_next[write_port_access_set_addr_in] = 1'b1;
      end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
        r_state <= FLUSH_IDLE;
        r_group <= '0;
        r_valid <= '0;
      end else begin
        r_state <= w_state_next;
        r_group <= w_group_next;
        r_valid <= w_valid_next;
      end
    end

    assign w_flush_busy  = (r_state == FLUSH_SWEEP);
    assign w_flush_done  = (r_state == FLUSH_DONE);
    assign w_valid_array = r_valid;
  end else begin : g_no_valid
    logic r_done;

    always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
        r_done <= 1'b0;
      end else begin
        r_done <= flush_req_in;
      end
    end

    assign w_flush_busy  = 1'b0;
    assign w_flush_done  = r_done;
    assign w_valid_array = '0;
  end

  for (genvar p = 0; p < NUM_READ_PORT; p++) begin : g_read_port
    logic [AW-1:0] w_raddr;
    logic          w_hit;

    assign w_raddr = read_port_access_set_addr_in[p*AW +: AW];
    assign w_hit   = w_write_accept && (write_port_access_set_addr_in == w_raddr);

    lutram_read_port #(
      .WIDTH          (WIDTH),
      .MASK_LEN       (WRITE_MASK_LEN),
      .IS_WRITE_FIRST (IS_WRITE_FIRST),
      .HAS_VALID      (HAS_VALID)
    ) u_read_port (
      .i_clk        (clk_in),
      .i_rst        (reset_in),
      .i_en         (read_port_access_en_in[p]),
      .i_row        (r_mem[w_raddr]),
      .i_valid_bit  (w_valid_array[w_raddr]),
      .i_busy       (w_flush_busy),
      .i_write_hit  (w_hit),
      .i_write_mask (write_port_write_en_in),
      .i_write_data (write_port_data_in),
      .o_data       (read_port_data_out[p*WIDTH +: WIDTH]),
      .o_valid      (read_port_valid_out[p])
    );
  end

  assign write_port_ready_out = !w_flush_busy;
  assign flush_busy_out       = w_flush_busy;
  assign flush_done_out       = w_flush_done;

endmodule
